fas_peak_detect: RTL

- Downstream consumer of the 16-point FFT stage. Captures one full frame of 16 complex bins when fft_valid pulses.
- Scans the bins sequentially, one per cycle, computing squared magnitude re^2 + im^2.
- Reports the index of the strongest bin on freq with a one-cycle done pulse. This is the final frequency-analysis result of the system.

---
 rtl/fas_pkg.sv | 30 +++
 rtl/fas_mag_sq.sv | 20 ++
 rtl/fas_peak_detect.sv | 92 +++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// Shared constants, FSM state type and bin-field helpers for the frequency-analysis stage.
package fas_pkg;

    localparam int DW    = 16;
    localparam int NBIN  = 16;
    localparam int IDX_W = 4;
    localparam int BIN_W = 2 * DW;
    localparam int MAG_W = 2 * DW + 1;

    // Bin word layout: real part in the high half, imaginary part in the low half
    localparam int RE_HI = BIN_W - 1;
    localparam int RE_LO = DW;
    localparam int IM_HI = DW - 1;
    localparam int IM_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic signed [DW-1:0] bin_re(input logic [BIN_W-1:0] bin);
        return bin[RE_HI:RE_LO];
    endfunction

    function automatic logic signed [DW-1:0] bin_im(input logic [BIN_W-1:0] bin);
        return bin[IM_HI:IM_LO];
    endfunction

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one complex sample, full precision.
module fas_mag_sq #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic        [2*DW:0] mag
);

    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;

    // A square is never negative and peaks at 2^(2*DW-2), so one extra bit holds the sum
    always_comb begin
        re_sq = (2*DW)'(re) * (2*DW)'(re);
        im_sq = (2*DW)'(im) * (2*DW)'(im);
        mag   = {1'b0, re_sq} + {1'b0, im_sq};
    end

endmodule

// File: rtl/fas_peak_detect.sv
// Captures a 16-bin FFT frame, scans it one bin per cycle and reports the peak-magnitude bin index.
// Build option FAS_SKIP_DC_EN: exclude bin 0 from the search.
module fas_peak_detect #(
    parameter int DW   = 16,
    parameter int NBIN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fft_valid,
    input  logic [NBIN*2*DW-1:0]     fft_d_flat,
    output logic                     in_ready,
    output logic                     done,
    output logic [fas_pkg::IDX_W-1:0] freq
);

    import fas_pkg::*;

`ifdef FAS_SKIP_DC_EN
    localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(0);
`endif
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NBIN - 1);

    state_e             state;
    logic [2*DW-1:0]    frame [NBIN];
    logic [IDX_W-1:0]   cnt;
    logic [2*DW:0]      max_mag;
    logic [IDX_W-1:0]   max_idx;
    logic               first;
    logic [2*DW:0]      mag;

    fas_mag_sq #(.DW(DW)) u_mag_sq (
        .re  (bin_re(frame[cnt])),
        .im  (bin_im(frame[cnt])),
        .mag (mag)
    );

    assign in_ready = (state == IDLE);

    // The frame register is written only in IDLE, so a busy-time strobe cannot disturb the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            freq    <= '0;
            cnt     <= '0;
            max_mag <= '0;
            max_idx <= '0;
            first   <= 1'b0;
            for (int k = 0; k < NBIN; k++) begin
                frame[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fft_valid) begin
                        for (int k = 0; k < NBIN; k++) begin
                            frame[k] <= fft_d_flat[k*2*DW +: 2*DW];
                        end
                        cnt     <= FIRST_BIN;
                        max_mag <= '0;
                        first   <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties
                    if (first || (mag > max_mag)) begin
                        max_mag <= mag;
                        max_idx <= cnt;
                        first   <= 1'b0;
                    end
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == LAST_BIN) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    freq  <= max_idx;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
